// File: rtl/inst_fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_queue_pkg
// Purpose  : Shared fetch-path types and constants. fetch_entry_t is the
//            record carried from fetch through the fetch queue into decode.
// Contents : ADDR_WIDTH, INST_WIDTH, RESET_VECTOR, fetch_entry_t
// Revision : 1.0 - initial release
// ============================================================================
package inst_fetch_queue_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int INST_WIDTH = 32;

    // First PC fetched after reset.
    localparam logic [ADDR_WIDTH-1:0] RESET_VECTOR = 32'h1C00_0000;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [INST_WIDTH-1:0] inst;
        logic                  branch;
        logic [ADDR_WIDTH-1:0] branch_addr;
    } fetch_entry_t;

endpackage : inst_fetch_queue_pkg
`default_nettype wire

// File: rtl/inst_fetch_queue_ptr.sv
`default_nettype none
// ============================================================================
// Module   : fq_ptr
// Purpose  : Wrapping queue pointer of $clog2(DEPTH) bits. DEPTH is a power
//            of two, so natural binary overflow gives the modulo wrap.
// Ports    : clk    - clock
//            rst    - synchronous active-low reset
//            i_clr  - synchronous clear (flush)
//            i_inc  - advance pointer by one
//            o_ptr  - current pointer value
// Revision : 1.0 - initial release
// ============================================================================
module fq_ptr #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clr,
    input  logic                     i_inc,
    output logic [$clog2(DEPTH)-1:0] o_ptr
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (!rst || i_clr) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + PTR_W'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule : fq_ptr
`default_nettype wire

// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_queue
// Purpose  : Flop-based FIFO between instruction fetch and decode. Head entry
//            is presented combinationally (zero read latency); flush empties
//            the queue in one cycle.
// Ports    : clk, rst (sync, active-low), flush
//            in_valid/in_ready, in_pc, in_inst, in_branch, in_branch_addr
//            out_valid/out_ready, out_pc, out_inst, out_branch, out_branch_addr
//            count - current occupancy
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_queue #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [ADDR_WIDTH-1:0]      in_pc,
    input  logic [INST_WIDTH-1:0]      in_inst,
    input  logic                       in_branch,
    input  logic [ADDR_WIDTH-1:0]      in_branch_addr,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [ADDR_WIDTH-1:0]      out_pc,
    output logic [INST_WIDTH-1:0]      out_inst,
    output logic                       out_branch,
    output logic [ADDR_WIDTH-1:0]      out_branch_addr,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count
);

    import inst_fetch_queue_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     r_mem [DEPTH];
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_head;
    logic [PTR_W-1:0] w_tail;
    logic             w_push;
    logic             w_pop;
    fetch_entry_t     w_in_entry;
    fetch_entry_t     w_head_entry;

    // in_ready deliberately ignores out_ready: a full queue never accepts,
    // which keeps the fetch stall off the decode timing path.
    assign in_ready  = (r_count != CNT_W'(DEPTH)) && rst;
    assign out_valid = (r_count != '0);

    assign w_push = in_valid && in_ready && !flush;
    assign w_pop  = out_valid && out_ready && !flush;

    fq_ptr #(.DEPTH(DEPTH)) u_head_ptr (
        .clk   (clk),
        .rst   (rst),
        .i_clr (flush),
        .i_inc (w_pop),
        .o_ptr (w_head)
    );

    fq_ptr #(.DEPTH(DEPTH)) u_tail_ptr (
        .clk   (clk),
        .rst   (rst),
        .i_clr (flush),
        .i_inc (w_push),
        .o_ptr (w_tail)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_in_entry = '{pc:          in_pc,
                          inst:        in_inst,
                          branch:      in_branch,
                          branch_addr: in_branch_addr};

    // Storage is zeroed on reset only; flush just rewinds the pointers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[w_tail] <= w_in_entry;
        end
    end

    assign w_head_entry    = r_mem[w_head];
    assign out_pc          = w_head_entry.pc;
    assign out_inst        = w_head_entry.inst;
    assign out_branch      = w_head_entry.branch;
    assign out_branch_addr = w_head_entry.branch_addr;
    assign count           = r_count;

endmodule : inst_fetch_queue
`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_queue
// Purpose  : Self-checking bench for inst_fetch_queue. A queue of expected
//            entries is updated as stimulus is applied; the head of that
//            queue is compared against out_* every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_queue;

    import inst_fetch_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        br;
        logic [31:0] ba;
    } ent_t;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic [31:0]      in_pc;
    logic [31:0]      in_inst;
    logic             in_branch;
    logic [31:0]      in_branch_addr;
    logic             in_ready;
    logic             out_valid;
    logic [31:0]      out_pc;
    logic [31:0]      out_inst;
    logic             out_branch;
    logic [31:0]      out_branch_addr;
    logic             out_ready;
    logic [CNT_W-1:0] count;

    int   checks;
    int   errors;
    ent_t sb[$];
    bit   mem_clean;

    inst_fetch_queue #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (32),
        .INST_WIDTH (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_pc           (in_pc),
        .in_inst         (in_inst),
        .in_branch       (in_branch),
        .in_branch_addr  (in_branch_addr),
        .in_ready        (in_ready),
        .out_valid       (out_valid),
        .out_pc          (out_pc),
        .out_inst        (out_inst),
        .out_branch      (out_branch),
        .out_branch_addr (out_branch_addr),
        .out_ready       (out_ready),
        .count           (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus, check outputs mid-cycle against the
    // model, then advance the model across the rising edge.
    task automatic cycle(input logic iv, input logic [31:0] pc, input logic br,
                         input logic [31:0] ba, input logic ordy, input logic fl);
        bit   push;
        bit   pop;
        ent_t e;
        in_valid       = iv;
        in_pc          = pc;
        in_inst        = pc ^ 32'hA5A5_0F0F;
        in_branch      = br;
        in_branch_addr = ba;
        out_ready      = ordy;
        flush          = fl;
        @(negedge clk);
        check("count", 64'(count), 64'(sb.size()));
        check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        check("in_ready", 64'(in_ready), 64'(rst && (sb.size() != DEPTH)));
        if (sb.size() != 0) begin
            check("out_pc", 64'(out_pc), 64'(sb[0].pc));
            check("out_inst", 64'(out_inst), 64'(sb[0].inst));
            check("out_branch", 64'(out_branch), 64'(sb[0].br));
            check("out_baddr", 64'(out_branch_addr), 64'(sb[0].ba));
        end else if (mem_clean) begin
            check("out_pc_zero", 64'(out_pc), 64'd0);
            check("out_inst_zero", 64'(out_inst), 64'd0);
            check("out_branch_zero", 64'(out_branch), 64'd0);
            check("out_baddr_zero", 64'(out_branch_addr), 64'd0);
        end
        if (!rst) begin
            sb.delete();
            mem_clean = 1'b1;
        end else if (fl) begin
            sb.delete();
        end else begin
            push = iv && (sb.size() != DEPTH);
            pop  = (sb.size() != 0) && ordy;
            if (pop) void'(sb.pop_front());
            if (push) begin
                e.pc   = pc;
                e.inst = pc ^ 32'hA5A5_0F0F;
                e.br   = br;
                e.ba   = ba;
                sb.push_back(e);
                mem_clean = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, ordy, 1'b0);
    endtask

    task automatic push1(input logic [31:0] pc, input logic ordy);
        cycle(1'b1, pc, 1'b0, 32'h0, ordy, 1'b0);
    endtask

    localparam logic [31:0] BASE = RESET_VECTOR;

    initial begin
        checks         = 0;
        errors         = 0;
        mem_clean      = 1'b0;
        rst            = 1'b0;
        flush          = 1'b0;
        in_valid       = 1'b0;
        in_pc          = '0;
        in_inst        = '0;
        in_branch      = 1'b0;
        in_branch_addr = '0;
        out_ready      = 1'b0;
        @(posedge clk);
        #1;
        mem_clean = 1'b1;

        // Held in reset: in_ready low, queue empty, fields zero.
        idle(1'b0);
        idle(1'b1);
        rst = 1'b1;

        // Three pushes, no pops.
        for (int i = 0; i < 3; i++) push1(BASE + 32'(4 * i), 1'b0);
        idle(1'b0);

        // Fill, then hold a fifth push that must be dropped.
        push1(BASE + 32'h0C, 1'b0);
        for (int i = 0; i < 3; i++) push1(BASE + 32'h10, 1'b0);
        // Full with a pop in the same cycle still refuses the push.
        push1(BASE + 32'h10, 1'b1);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Steady state push+pop from count=2, wrapping the pointers.
        push1(BASE + 32'h20, 1'b0);
        push1(BASE + 32'h24, 1'b0);
        for (int i = 0; i < 10; i++) push1(BASE + 32'h28 + 32'(4 * i), 1'b1);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Flush beats concurrent push and pop.
        for (int i = 0; i < 3; i++) push1(BASE + 32'h80 + 32'(4 * i), 1'b0);
        cycle(1'b1, BASE + 32'h200, 1'b0, 32'h0, 1'b1, 1'b1);
        push1(BASE + 32'h100, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);

        // Branch fields travel with their instruction.
        push1(BASE + 32'h300, 1'b0);
        cycle(1'b1, BASE + 32'h304, 1'b1, BASE + 32'h400, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Random traffic with occasional flush.
        for (int i = 0; i < 80; i++) begin
            cycle(1'($urandom_range(0, 1)), BASE + 32'h1000 + 32'(4 * i),
                  1'($urandom_range(0, 1)), 32'($urandom),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        end
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Reset mid-operation with two entries queued.
        push1(BASE + 32'h500, 1'b0);
        push1(BASE + 32'h504, 1'b0);
        rst = 1'b0;
        cycle(1'b1, BASE + 32'h508, 1'b0, 32'h0, 1'b1, 1'b0);
        rst = 1'b1;
        idle(1'b0);
        idle(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_inst_fetch_queue
`default_nettype wire
